// File: rtl/sign_mag_adder_serial.sv
// Bit-serial sign-magnitude adder.
// A start request latches both operands; one cycle decides add vs. subtract
// and which magnitude is larger, then the magnitudes are combined one bit per
// cycle (LSB first) with a registered carry/borrow. The result is published
// on entry to DONE together with a magnitude carry-out flag.
module sign_mag_adder_serial #(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Overflow,
    output logic             Done
);

    localparam int MW = WIDTH - 1;                     // magnitude width
    localparam int CW = (MW > 1) ? $clog2(MW) : 1;     // bit counter width

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] ADD     = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [MW-1:0]    a_mag_q, a_mag_d;
    logic [MW-1:0]    b_mag_q, b_mag_d;
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic             sub_q, sub_d;       // effective operation is subtract
    logic             swap_q, swap_d;     // B magnitude is the larger one
    logic             sign_q, sign_d;     // sign of the result before zero fix-up
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;   // carry (add) or borrow (subtract)
    logic [MW-1:0]    res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic             last_bit;
    logic             x_bit, y_bit;
    logic             bit_res, carry_nxt;
    logic [MW-1:0]    res_upd;

    // One-bit full adder / full subtractor on the current magnitude bit.
    // x is always the larger magnitude so subtraction never ends in a borrow.
    always_comb begin
        last_bit  = (cnt_q == CW'(MW - 1));
        x_bit     = swap_q ? b_mag_q[cnt_q] : a_mag_q[cnt_q];
        y_bit     = swap_q ? a_mag_q[cnt_q] : b_mag_q[cnt_q];
        bit_res   = x_bit ^ y_bit ^ carry_q;
        if (sub_q) begin
            carry_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & carry_q);
        end else begin
            carry_nxt = (x_bit & y_bit) | (carry_q & (x_bit ^ y_bit));
        end
        res_upd          = res_q;
        res_upd[cnt_q]   = bit_res;
    end

    // Next-state and datapath update for the four-state sequencer.
    always_comb begin
        state_d  = state_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        sub_d    = sub_q;
        swap_d   = swap_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        res_d    = res_q;
        sum_d    = sum_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_mag_d  = A[MW-1:0];
                    a_sign_d = A[WIDTH-1];
                    b_mag_d  = B[MW-1:0];
                    b_sign_d = B[WIDTH-1];
                    state_d  = COMPARE;
                end
            end
            COMPARE: begin
                sub_d = a_sign_q ^ b_sign_q;
                // Equal magnitudes keep A as the larger operand.
                if ((a_sign_q ^ b_sign_q) && (b_mag_q > a_mag_q)) begin
                    swap_d = 1'b1;
                    sign_d = b_sign_q;
                end else begin
                    swap_d = 1'b0;
                    sign_d = a_sign_q;
                end
                cnt_d   = '0;
                carry_d = 1'b0;
                res_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                res_d   = res_upd;
                carry_d = carry_nxt;
                if (last_bit) begin
                    // A zero magnitude always reports a positive sign.
                    sum_d   = {sign_q & (|res_upd), res_upd};
                    ovf_d   = ~sub_q & carry_nxt;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= IDLE;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            sub_q    <= 1'b0;
            swap_q   <= 1'b0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            res_q    <= '0;
            sum_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            sub_q    <= sub_d;
            swap_q   <= swap_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            res_q    <= res_d;
            sum_q    <= sum_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Ready    = (state_q == IDLE);
    assign Done     = (state_q == DONE);
    assign Sum      = sum_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_sign_mag_adder_serial.sv
// Scoreboard bench for the serial sign-magnitude adder: the driver pushes the
// expected {Overflow, Sum} from an integer-arithmetic model, the monitor pops
// and compares on every Done pulse.
module tb_sign_mag_adder_serial;

    localparam int W = 16;

    logic         Clk;
    logic         Reset_n;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Ready;
    logic [W-1:0] Sum;
    logic         Overflow;
    logic         Done;

    int checks = 0;
    int errors = 0;

    logic [W:0] exp_q[$];
    logic [W:0] last_exp;

    sign_mag_adder_serial #(.WIDTH(W)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Ready   (Ready),
        .Sum     (Sum),
        .Overflow(Overflow),
        .Done    (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Signed-integer reference: add the two values, then fold back into
    // sign-magnitude with wrap-around on the magnitude field.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int          va, vb, s, abs_s, mag;
        logic        ovf, sgn;
        logic [W-1:0] res;
        va    = a[W-1] ? -int'(a[W-2:0]) : int'(a[W-2:0]);
        vb    = b[W-1] ? -int'(b[W-2:0]) : int'(b[W-2:0]);
        s     = va + vb;
        abs_s = (s < 0) ? -s : s;
        ovf   = (abs_s >= (1 << (W - 1)));
        mag   = abs_s % (1 << (W - 1));
        sgn   = (s < 0) && (mag != 0);
        res   = {sgn, mag[W-2:0]};
        return {ovf, res};
    endfunction

    task automatic check(input string name, input logic [W:0] got, input logic [W:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got Done=1 with no pending operation, want none");
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", {Overflow, Sum}, e);
            end
        end
    end

    // Issue Start with the given operands; returns just after the sampling edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        A     = a;
        B     = b;
        Start = 1'b1;
        @(posedge Clk);
        #1;
        Start    = 1'b0;
        last_exp = model(a, b);
        exp_q.push_back(last_exp);
    endtask

    // Follow the operation edge by edge: Done must appear exactly W edges after
    // the sampling edge, Ready must stay low meanwhile. Optionally keep Start
    // high with disturbed operands for the first hold edges.
    task automatic wait_done(input int hold);
        logic bad;
        logic seen;
        bad  = 1'b0;
        seen = 1'b0;
        if (hold > 0) begin
            Start = 1'b1;
            A     = 16'h7000;
        end
        for (int i = 1; i <= W; i++) begin
            @(posedge Clk);
            #1;
            if (i == hold) Start = 1'b0;
            if (i < W && (Done || Ready)) bad = 1'b1;
            if (i == W) seen = Done && !Ready;
        end
        check("latency", {15'd0, bad, seen}, {15'd0, 1'b0, 1'b1});
        @(posedge Clk);
        #1;
        check("done_pulse_end", {15'd0, Done, Ready}, {15'd0, 1'b0, 1'b1});
    endtask

    // Hard bound on the whole run.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got run still active, want finished");
        $fatal(1, "timeout");
    end

    logic [W-1:0] va_tab [8];
    logic [W-1:0] vb_tab [8];

    initial begin
        va_tab = '{16'h0005, 16'h0005, 16'h8005, 16'h0003, 16'h0003, 16'h8000, 16'h7FFF, 16'hFFFF};
        vb_tab = '{16'h0003, 16'h8003, 16'h0003, 16'h8005, 16'h8003, 16'h8000, 16'h0001, 16'h8002};

        Reset_n = 1'b0;
        Start   = 1'b0;
        A       = '0;
        B       = '0;
        #12;
        check("reset_state", {Overflow, Sum}, '0);
        check("reset_flags", {15'd0, Ready, Done}, {15'd0, 1'b1, 1'b0});
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        // Directed vectors, including equal magnitudes, -0 and overflow.
        for (int i = 0; i < 8; i++) begin
            start_op(va_tab[i], vb_tab[i]);
            wait_done(0);
        end

        // Outputs hold through idle.
        repeat (3) @(posedge Clk);
        #1;
        check("hold_idle", {Overflow, Sum}, last_exp);

        // Start and operand changes while busy are ignored.
        start_op(16'h0001, 16'h0001);
        wait_done(9);
        check("busy_ignored", {Overflow, Sum}, {1'b0, 16'h0002});

        // Reset in mid-operation aborts with no Done pulse.
        start_op(16'h0005, 16'h0003);
        repeat (6) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("abort_outputs", {Overflow, Sum}, '0);
        check("abort_flags", {15'd0, Ready, Done}, {15'd0, 1'b1, 1'b0});
        repeat (2) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        start_op(16'h0001, 16'h0001);
        wait_done(0);
        check("after_abort", {Overflow, Sum}, {1'b0, 16'h0002});

        // Randomized operands, biased toward extreme magnitudes.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 3))
                0: ra[W-2:0] = '0;
                1: ra[W-2:0] = '1;
                2: rb[W-2:0] = ra[W-2:0];
                default: ;
            endcase
            start_op(ra, rb);
            wait_done(0);
        end

        repeat (4) @(posedge Clk);
        #1;
        check("queue_drained", (W+1)'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
